// File: rtl/cov_watchdog.sv
// Coverage-stall watchdog: tracks best cov_sum and fires a META_CYCLES-long meta_reset after `timeout` stalled cycles.
// All outputs registered (1-cycle latency from sampling edge); no backpressure, cov_sum is sampled every RUN cycle.
module cov_watchdog #(
  parameter int COV_WIDTH     = 32,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int META_CYCLES   = 16,
  parameter int ROUND_WIDTH   = 16,
  parameter bit GLOBAL_BEST   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic [COV_WIDTH-1:0]     cov_sum,
  output logic                     meta_reset,
  output logic                     new_cov,
  output logic [COV_WIDTH-1:0]     best_cov,
  output logic [TIMEOUT_WIDTH-1:0] stall_cnt,
  output logic [ROUND_WIDTH-1:0]   round_cnt,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, META = 2'd2} state_t;

  localparam int MW = (META_CYCLES > 1) ? $clog2(META_CYCLES) : 1;
  localparam logic [MW-1:0] META_LAST = MW'(META_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [MW-1:0]            meta_cnt_q, meta_cnt_d;
  logic [COV_WIDTH-1:0]     best_q, best_d;
  logic [TIMEOUT_WIDTH-1:0] stall_q, stall_d;
  logic [ROUND_WIDTH-1:0]   round_q, round_d;
  logic                     meta_q, meta_d;
  logic                     new_cov_q, new_cov_d;
  logic                     busy_q, busy_d;

  logic progress;
  logic timeout_due;
  logic meta_last;

  assign progress = cov_sum > best_q;
  // Compare one bit wider so stall_q+1 cannot wrap; timeout is used live, so lowering it fires at once.
  assign timeout_due = (timeout != '0) &&
                       (((TIMEOUT_WIDTH+1)'(stall_q) + (TIMEOUT_WIDTH+1)'(1)) >= (TIMEOUT_WIDTH+1)'(timeout));
  assign meta_last = (meta_cnt_q == META_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable) state_d = IDLE;
        else if (!progress && timeout_due) state_d = META;
      end
      META: if (meta_last) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    meta_cnt_d = meta_cnt_q;
    best_d     = best_q;
    stall_d    = stall_q;
    round_d    = round_q;
    meta_d     = meta_q;
    new_cov_d  = 1'b0;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: stall_d = '0;
      RUN: begin
        if (!enable) begin
          stall_d = '0;
        end else if (progress) begin
          best_d    = cov_sum;
          stall_d   = '0;
          new_cov_d = 1'b1;
        end else if (timeout_due) begin
          meta_d     = 1'b1;
          meta_cnt_d = '0;
          round_d    = (round_q == '1) ? round_q : round_q + ROUND_WIDTH'(1);
          stall_d    = '0;
          if (!GLOBAL_BEST) best_d = '0;
        end else begin
          stall_d = (stall_q == '1) ? stall_q : stall_q + TIMEOUT_WIDTH'(1);
        end
      end
      META: begin
        // The pulse always runs to full length; enable only picks the exit state.
        if (meta_last) meta_d = 1'b0;
        else meta_cnt_d = meta_cnt_q + MW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_cnt_q <= '0;
      best_q     <= '0;
      stall_q    <= '0;
      round_q    <= '0;
      meta_q     <= 1'b0;
      new_cov_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      meta_cnt_q <= meta_cnt_d;
      best_q     <= best_d;
      stall_q    <= stall_d;
      round_q    <= round_d;
      meta_q     <= meta_d;
      new_cov_q  <= new_cov_d;
      busy_q     <= busy_d;
    end
  end

  assign meta_reset = meta_q;
  assign new_cov    = new_cov_q;
  assign best_cov   = best_q;
  assign stall_cnt  = stall_q;
  assign round_cnt  = round_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cov_watchdog.sv
// Scoreboard bench for cov_watchdog: stimulus queues expected meta_reset edges and new_cov pulses,
// a negedge monitor pops and compares each one the DUTs actually produce.
module tb_cov_watchdog;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_NEW  = 2;

  typedef struct {
    int inst;
    int kind;
    int cyc;
    longint val;
  } ev_t;

  bit clk = 1'b0;
  logic rst;
  int cyc = 0;
  int nvec = 0;
  int nmis = 0;
  ev_t q[$];

  logic        a_en, a_mr, a_nc, a_busy;
  logic [23:0] a_to, a_stall;
  logic [31:0] a_cov, a_best;
  logic [15:0] a_round;

  logic        b_en, b_mr, b_nc, b_busy;
  logic [23:0] b_to, b_stall;
  logic [31:0] b_cov, b_best;
  logic [1:0]  b_round;

  cov_watchdog dut_a (
    .clock(clk), .reset(rst), .enable(a_en), .timeout(a_to), .cov_sum(a_cov),
    .meta_reset(a_mr), .new_cov(a_nc), .best_cov(a_best), .stall_cnt(a_stall),
    .round_cnt(a_round), .busy(a_busy)
  );

  cov_watchdog #(
    .COV_WIDTH(32), .TIMEOUT_WIDTH(24), .META_CYCLES(4), .ROUND_WIDTH(2), .GLOBAL_BEST(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst), .enable(b_en), .timeout(b_to), .cov_sum(b_cov),
    .meta_reset(b_mr), .new_cov(b_nc), .best_cov(b_best), .stall_cnt(b_stall),
    .round_cnt(b_round), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint want);
    nvec++;
    if (act != want) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expect_ev(input int inst, input int kind, input int c, input longint val);
    ev_t e;
    e.inst = inst; e.kind = kind; e.cyc = c; e.val = val;
    q.push_back(e);
  endtask

  task automatic seen(input int inst, input int kind, input longint val);
    ev_t e;
    nvec++;
    if (q.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_event: got inst=%0d kind=%0d cyc=%0d val=%0d expected no event",
               inst, kind, cyc, val);
    end else begin
      e = q.pop_front();
      if (e.inst != inst || e.kind != kind || e.cyc != cyc || e.val != val) begin
        nmis++;
        $display("FAIL event: got inst=%0d kind=%0d cyc=%0d val=%0d expected inst=%0d kind=%0d cyc=%0d val=%0d",
                 inst, kind, cyc, val, e.inst, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: every meta_reset edge and every new_cov cycle is an event the scoreboard must have predicted.
  logic a_mr_prev = 1'b0;
  logic b_mr_prev = 1'b0;
  always @(negedge clk) begin
    if (a_mr === 1'b1 && a_mr_prev === 1'b0) seen(0, K_RISE, longint'(a_round));
    if (a_mr === 1'b0 && a_mr_prev === 1'b1) seen(0, K_FALL, longint'(a_round));
    if (a_nc === 1'b1) seen(0, K_NEW, longint'(a_best));
    if (b_mr === 1'b1 && b_mr_prev === 1'b0) seen(1, K_RISE, longint'(b_round));
    if (b_mr === 1'b0 && b_mr_prev === 1'b1) seen(1, K_FALL, longint'(b_round));
    if (b_nc === 1'b1) seen(1, K_NEW, longint'(b_best));
    a_mr_prev = a_mr;
    b_mr_prev = b_mr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drain(input string name);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    int p;
    rst = 1'b1;
    a_en = 1'b0; a_to = '0; a_cov = '0;
    b_en = 1'b0; b_to = '0; b_cov = '0;
    tick(3);
    chk("rst_meta_reset", a_mr, 0);
    chk("rst_new_cov", a_nc, 0);
    chk("rst_best_cov", a_best, 0);
    chk("rst_stall_cnt", a_stall, 0);
    chk("rst_round_cnt", a_round, 0);
    chk("rst_busy", a_busy, 0);
    rst = 1'b0;
    tick(1);

    // timeout=0 never fires
    p = cyc; a_en = 1'b1; a_to = 24'd0; a_cov = 32'd0;
    goto(p + 1000);
    chk("to0_stall", a_stall, 999);
    chk("to0_round", a_round, 0);
    chk("to0_busy", a_busy, 1);
    a_en = 1'b0;
    tick(2);
    chk("idle_stall", a_stall, 0);
    chk("idle_busy", a_busy, 0);
    drain("to0_drain");

    // basic timeout, back-to-back rounds, enable dropped mid-META
    p = cyc; a_to = 24'd5; a_en = 1'b1;
    expect_ev(0, K_RISE, p + 6, 1);
    expect_ev(0, K_FALL, p + 22, 1);
    expect_ev(0, K_RISE, p + 27, 2);
    expect_ev(0, K_FALL, p + 43, 2);
    goto(p + 30);
    chk("basic_round", a_round, 2);
    chk("basic_busy_meta", a_busy, 1);
    a_en = 1'b0;
    goto(p + 45);
    chk("basic_busy_after", a_busy, 0);
    chk("basic_mr_after", a_mr, 0);
    drain("basic_drain");

    // progress clears the stall count; a decrease is not progress
    p = cyc; a_en = 1'b1;
    expect_ev(0, K_NEW, p + 4, 10);
    expect_ev(0, K_RISE, p + 9, 3);
    expect_ev(0, K_FALL, p + 25, 3);
    goto(p + 3); a_cov = 32'd10;
    goto(p + 4);
    chk("prog_stall", a_stall, 0);
    chk("prog_best", a_best, 10);
    goto(p + 5); a_cov = 32'd8;
    goto(p + 9); a_en = 1'b0;
    goto(p + 28);
    chk("prog_busy", a_busy, 0);
    chk("prog_best_kept", a_best, 10);
    drain("prog_drain");

    // progress beats a due timeout; enable drop on the timeout edge suppresses META
    p = cyc; a_to = 24'd3; a_cov = 32'd10; a_en = 1'b1;
    expect_ev(0, K_NEW, p + 4, 11);
    expect_ev(0, K_RISE, p + 7, 4);
    expect_ev(0, K_FALL, p + 23, 4);
    goto(p + 3); a_cov = 32'd11;
    goto(p + 4);
    chk("beat_stall", a_stall, 0);
    chk("beat_mr", a_mr, 0);
    goto(p + 25); a_en = 1'b0;
    goto(p + 27);
    chk("drop_round", a_round, 4);
    chk("drop_busy", a_busy, 0);
    chk("global_best_kept", a_best, 11);
    drain("beat_drain");

    // timeout lowered under the stall count, then async reset mid-META
    p = cyc; a_to = 24'd100; a_cov = 32'd0; a_en = 1'b1;
    expect_ev(0, K_RISE, p + 42, 5);
    expect_ev(0, K_FALL, p + 47, 0);
    goto(p + 41);
    chk("lower_stall", a_stall, 40);
    a_to = 24'd2;
    goto(p + 47);
    rst = 1'b1;
    #1;
    chk("arst_mr", a_mr, 0);
    chk("arst_nc", a_nc, 0);
    chk("arst_best", a_best, 0);
    chk("arst_stall", a_stall, 0);
    chk("arst_round", a_round, 0);
    chk("arst_busy", a_busy, 0);
    tick(2);
    rst = 1'b0; a_en = 1'b0;
    tick(1);
    drain("lower_drain");

    // per-round best (GLOBAL_BEST=0), META_CYCLES=4, 2-bit round_cnt saturation
    p = cyc; b_to = 24'd3; b_cov = 32'd50; b_en = 1'b1;
    expect_ev(1, K_NEW, p + 2, 50);
    expect_ev(1, K_RISE, p + 5, 1);
    expect_ev(1, K_FALL, p + 9, 1);
    expect_ev(1, K_NEW, p + 10, 1);
    expect_ev(1, K_RISE, p + 13, 2);
    expect_ev(1, K_FALL, p + 17, 2);
    expect_ev(1, K_NEW, p + 18, 1);
    expect_ev(1, K_RISE, p + 21, 3);
    expect_ev(1, K_FALL, p + 25, 3);
    expect_ev(1, K_NEW, p + 26, 1);
    expect_ev(1, K_RISE, p + 29, 3);
    expect_ev(1, K_FALL, p + 33, 3);
    goto(p + 5);
    chk("local_best_cleared", b_best, 0);
    b_cov = 32'd1;
    goto(p + 33); b_en = 1'b0;
    goto(p + 35);
    chk("sat_round", b_round, 3);
    chk("sat_busy", b_busy, 0);
    drain("local_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
